// File: rtl/zbuff_tile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | zbuff_tile_pkg : shared types and constants for the tile z-buffer    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package zbuff_tile_pkg;

  localparam int ZB_SIGFIG  = 24;
  localparam int ZB_RADIX   = 10;
  localparam int ZB_LANES   = 2;
  localparam int ZB_COLORS  = 3;
  localparam int ZB_TILE_L2 = 3;
  localparam int ZB_SS_L2   = 3;
  localparam int ZB_CNT_W   = 16;

  localparam logic [3:0] RATE_1X = 4'b1000;
  localparam logic [3:0] RATE_2X = 4'b0100;
  localparam logic [3:0] RATE_4X = 4'b0010;
  localparam logic [3:0] RATE_8X = 4'b0001;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DUMP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [ZB_SIGFIG-1:0]                depth;
    logic [ZB_COLORS-1:0][ZB_SIGFIG-1:0] color;
  } word_t;

  // frac holds the three most significant fraction bits of a coordinate
  function automatic logic [ZB_SS_L2-1:0] ss_bits(input logic [3:0] rate,
                                                  input logic [2:0] frac);
    case (rate)
      RATE_2X: return {2'b00, frac[2]};
      RATE_4X: return {1'b0, frac[2:1]};
      RATE_8X: return frac;
      default: return '0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/zbuff_tile_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | zbuff_tile_if : hit input, control and readout bundle of the z-buffer|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface zbuff_tile_if
  import zbuff_tile_pkg::*;
#(
  parameter int LANES  = ZB_LANES,
  parameter int SIGFIG = ZB_SIGFIG,
  parameter int COLORS = ZB_COLORS,
  parameter int CNT_W  = ZB_CNT_W
) ();

  logic [3:0]                               subSample_RnnnnU;
  logic [LANES-1:0]                         hit_valid;
  logic [LANES-1:0]                         hit_ready;
  logic [LANES-1:0][2:0][SIGFIG-1:0]        hit_xyz;
  logic [LANES-1:0][COLORS-1:0][SIGFIG-1:0] hit_color;
  logic                                     clear_req;
  logic                                     dump_req;
  logic                                     busy;
  logic                                     pix_valid;
  logic                                     pix_ready;
  logic [COLORS-1:0][SIGFIG-1:0]            pix_color;
  logic                                     pix_last;
  logic [CNT_W-1:0]                         drop_count;

  modport master (
    output subSample_RnnnnU, hit_valid, hit_xyz, hit_color, clear_req, dump_req, pix_ready,
    input  hit_ready, busy, pix_valid, pix_color, pix_last, drop_count
  );

  modport slave (
    input  subSample_RnnnnU, hit_valid, hit_xyz, hit_color, clear_req, dump_req, pix_ready,
    output hit_ready, busy, pix_valid, pix_color, pix_last, drop_count
  );

endinterface
`default_nettype wire

// File: rtl/zbuff_tile_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | zbuff_tile_arb : round-robin lane arbiter with grant hold            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module zbuff_tile_arb #(
  parameter  int LANES = 2,
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [LANES-1:0] i_req,
  input  wire logic             i_hold,
  output logic      [LANES-1:0] o_grant,
  output logic      [LW-1:0]    o_idx
);

  logic [LW-1:0] r_ptr;
  logic          w_found;

  // o_idx is independent of i_hold so the caller may derive the hold from it
  always_comb begin
    w_found = 1'b0;
    o_idx   = r_ptr;
    for (int k = 0; k < LANES; k++) begin
      if (!w_found && i_req[LW'((int'(r_ptr) + k) % LANES)]) begin
        w_found = 1'b1;
        o_idx   = LW'((int'(r_ptr) + k) % LANES);
      end
    end
  end

  always_comb begin
    o_grant = '0;
    if (w_found && !i_hold) o_grant[o_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_found && !i_hold) begin
      r_ptr <= (o_idx == LW'(LANES - 1)) ? '0 : o_idx + LW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/zbuff_tile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | zbuff_tile : tile depth/colour store with read-compare-write pipeline|
// | Option macro ZBUFF_TILE_FWD_EN builds the stage-B forwarding path.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module zbuff_tile
  import zbuff_tile_pkg::*;
#(
  parameter int SIGFIG  = ZB_SIGFIG,
  parameter int RADIX   = ZB_RADIX,
  parameter int LANES   = ZB_LANES,
  parameter int COLORS  = ZB_COLORS,
  parameter int TILE_L2 = ZB_TILE_L2,
  parameter int SS_L2   = ZB_SS_L2,
  parameter int CNT_W   = ZB_CNT_W
) (
  input wire logic   clk,
  input wire logic   rst,
  zbuff_tile_if.slave bus
);

  localparam int AW    = 2 * (TILE_L2 + SS_L2);
  localparam int DEPTH = 1 << AW;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int HW    = SIGFIG - RADIX + 3;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e                        r_state, w_next;
  logic [AW-1:0]                 r_cnt;
  logic                          r_clr_pend;
  logic                          r_pix_valid;
  logic [CNT_W-1:0]              r_drop;
  word_t                         r_mem [DEPTH];
  word_t                         r_rd_q;
  logic                          r_b_valid;
  logic [AW-1:0]                 r_b_addr;
  logic [SIGFIG-1:0]             r_b_z;
  logic [COLORS-1:0][SIGFIG-1:0] r_b_color;

  logic             w_busy, w_hold, w_stall, w_xfer, w_oob, w_b_we, w_we, w_rd_en;
  logic [LANES-1:0] w_grant;
  logic [LW-1:0]    w_idx;
  logic [HW-1:0]    w_x_hi, w_y_hi;
  logic [AW-1:0]    w_addr_a, w_waddr, w_rd_addr;
  word_t            w_old, w_wdata;

  zbuff_tile_arb #(.LANES(LANES)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (bus.hit_valid),
    .i_hold  (w_hold),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  // Integer part plus the three leading fraction bits of the candidate lane
  assign w_x_hi   = bus.hit_xyz[w_idx][0][SIGFIG-1:RADIX-3];
  assign w_y_hi   = bus.hit_xyz[w_idx][1][SIGFIG-1:RADIX-3];
  assign w_oob    = (|w_x_hi[HW-1:TILE_L2+3]) | (|w_y_hi[HW-1:TILE_L2+3]);
  assign w_addr_a = {w_y_hi[TILE_L2+2:3], ss_bits(bus.subSample_RnnnnU, w_y_hi[2:0]),
                     w_x_hi[TILE_L2+2:3], ss_bits(bus.subSample_RnnnnU, w_x_hi[2:0])};

  assign w_hold = (r_state != ST_IDLE) || w_stall;
  assign w_xfer = |w_grant;
  assign w_b_we = r_b_valid && (r_b_z < w_old.depth);

`ifdef ZBUFF_TILE_FWD_EN
  logic          r_wr_valid;
  logic [AW-1:0] r_wr_addr;
  word_t         r_wr_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_word  <= '0;
    end else begin
      r_wr_valid <= w_b_we;
      r_wr_addr  <= r_b_addr;
      r_wr_word  <= w_wdata;
    end
  end

  assign w_stall = 1'b0;
  assign w_old   = (r_wr_valid && (r_wr_addr == r_b_addr)) ? r_wr_word : r_rd_q;
`else
  assign w_stall = w_b_we && (w_addr_a == r_b_addr);
  assign w_old   = r_rd_q;
`endif

  always_comb begin
    w_we          = w_b_we;
    w_waddr       = r_b_addr;
    w_wdata.depth = r_b_z;
    w_wdata.color = r_b_color;
    if (r_state == ST_CLEAR) begin
      w_we          = 1'b1;
      w_waddr       = r_cnt;
      w_wdata.depth = '1;
      w_wdata.color = '0;
    end
  end

  // During readout the port prefetches the next entry only when the current one is taken
  assign w_rd_addr = (r_state != ST_DUMP) ? w_addr_a : (r_pix_valid ? r_cnt + AW'(1) : r_cnt);
  assign w_rd_en   = (r_state != ST_DUMP) || !r_pix_valid || bus.pix_ready;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)          r_rd_q <= '0;
    else if (w_rd_en) r_rd_q <= r_mem[w_rd_addr];
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b1;
    case (r_state)
      ST_CLEAR: if (r_cnt == LAST) w_next = ST_IDLE;
      ST_IDLE: begin
        w_busy = 1'b0;
        if (bus.clear_req || bus.dump_req) w_next = ST_DRAIN;
      end
      ST_DRAIN: if (r_cnt[0]) w_next = r_clr_pend ? ST_CLEAR : ST_DUMP;
      ST_DUMP:  if (r_pix_valid && bus.pix_ready && (r_cnt == LAST)) w_next = ST_IDLE;
      default:  w_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_CLEAR;
      r_cnt       <= '0;
      r_clr_pend  <= 1'b0;
      r_pix_valid <= 1'b0;
      r_drop      <= '0;
      r_b_valid   <= 1'b0;
      r_b_addr    <= '0;
      r_b_z       <= '0;
      r_b_color   <= '0;
    end else begin
      r_state   <= w_next;
      r_b_valid <= w_xfer && !w_oob;
      r_b_addr  <= w_addr_a;
      r_b_z     <= bus.hit_xyz[w_idx][2];
      r_b_color <= bus.hit_color[w_idx];
      if (w_xfer && w_oob && (r_drop != '1)) r_drop <= r_drop + CNT_W'(1);
      case (r_state)
        ST_CLEAR: r_cnt <= r_cnt + AW'(1);
        ST_IDLE: begin
          if (bus.clear_req || bus.dump_req) begin
            r_cnt      <= '0;
            r_clr_pend <= bus.clear_req;
          end
        end
        ST_DRAIN: r_cnt <= r_cnt[0] ? '0 : r_cnt + AW'(1);
        ST_DUMP: begin
          if (!r_pix_valid) begin
            r_pix_valid <= 1'b1;
          end else if (bus.pix_ready) begin
            r_cnt <= r_cnt + AW'(1);
            if (r_cnt == LAST) r_pix_valid <= 1'b0;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign bus.hit_ready  = w_grant;
  assign bus.busy       = w_busy;
  assign bus.pix_valid  = r_pix_valid;
  assign bus.pix_color  = r_pix_valid ? r_rd_q.color : '0;
  assign bus.pix_last   = r_pix_valid && (r_cnt == LAST);
  assign bus.drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_zbuff_tile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_zbuff_tile : directed self-checking bench for zbuff_tile          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_zbuff_tile;
  import zbuff_tile_pkg::*;

  localparam int SIGFIG = 24;
  localparam int LANES  = 2;
  localparam int COLORS = 3;
  localparam int CNT_W  = 16;
  localparam int DEPTH  = 4096;
  localparam int CW     = COLORS * SIGFIG;
`ifdef ZBUFF_TILE_FWD_EN
  localparam int GAP = 0;
`else
  localparam int GAP = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  zbuff_tile_if #(.LANES(LANES), .SIGFIG(SIGFIG), .COLORS(COLORS), .CNT_W(CNT_W)) bus ();
  zbuff_tile dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int          n_checks = 0;
  int          n_errors = 0;
  logic [CW-1:0]     exp_col [DEPTH];
  logic [SIGFIG-1:0] exp_z   [DEPTH];
  logic [CW-1:0]     got     [DEPTH];

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] rgb3(input int a, input int b, input int c);
    return {SIGFIG'(c), SIGFIG'(b), SIGFIG'(a)};
  endfunction

  function automatic logic [CW-1:0] rgb(input int v);
    return rgb3(v, v, v);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      exp_col[i] = '0;
      exp_z[i]   = '1;
    end
  endfunction

  function automatic void model_hit(input int addr, input int z, input logic [CW-1:0] col);
    if (SIGFIG'(z) < exp_z[addr]) begin
      exp_z[addr]   = SIGFIG'(z);
      exp_col[addr] = col;
    end
  endfunction

  function automatic int img_diff();
    int d = 0;
    for (int i = 0; i < DEPTH; i++) if (got[i] !== exp_col[i]) d++;
    return d;
  endfunction

  task automatic send(input int lane, input int x, input int y, input int z,
                      input logic [CW-1:0] col, output int waits);
    @(negedge clk);
    bus.hit_valid          = '0;
    bus.hit_valid[lane]    = 1'b1;
    bus.hit_xyz[lane][0]   = SIGFIG'(x);
    bus.hit_xyz[lane][1]   = SIGFIG'(y);
    bus.hit_xyz[lane][2]   = SIGFIG'(z);
    bus.hit_color[lane]    = col;
    #1;
    waits = 0;
    while (!bus.hit_ready[lane] && waits < 50) begin
      @(negedge clk); #1;
      waits++;
    end
    if (waits >= 50) check("send_timeout", waits, 0);
  endtask

  task automatic idle_hits();
    @(negedge clk);
    bus.hit_valid = '0;
  endtask

  task automatic do_dump(input bit toggle, output int beats, output int lasts,
                         output int last_idx, output int unstable, output int lat);
    int            cyc = 0;
    bit            rdy, have_prev = 1'b0;
    logic [CW-1:0] prev_col = '0;
    logic          prev_last = 1'b0;
    beats = 0; lasts = 0; last_idx = -1; unstable = 0; lat = -1;
    @(negedge clk);
    bus.dump_req = 1'b1;
    while (beats < DEPTH && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      bus.dump_req  = 1'b0;
      rdy           = toggle ? ((cyc % 2) == 1) : 1'b1;
      bus.pix_ready = rdy;
      #1;
      if (bus.pix_valid && lat < 0) lat = cyc;
      if (have_prev && (!bus.pix_valid || bus.pix_color !== prev_col || bus.pix_last !== prev_last))
        unstable++;
      have_prev = bus.pix_valid && !rdy;
      prev_col  = bus.pix_color;
      prev_last = bus.pix_last;
      if (bus.pix_valid && rdy) begin
        got[beats] = bus.pix_color;
        if (bus.pix_last) begin
          lasts++;
          last_idx = beats;
        end
        beats++;
      end
    end
    @(negedge clk);
    bus.pix_ready = 1'b0;
  endtask

  initial begin
    int w, n, beats, lasts, last_idx, unst, lat, i0, i1, cyc;
    logic [31:0] seq;
    bit pv_seen;
    bus.subSample_RnnnnU = RATE_1X;
    bus.hit_valid = '0;
    bus.hit_xyz   = '0;
    bus.hit_color = '0;
    bus.clear_req = 1'b0;
    bus.dump_req  = 1'b0;
    bus.pix_ready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    bus.hit_valid = '1;
    #1;
    check("rst_ready", bus.hit_ready, 0);
    check("rst_busy", bus.busy, 1);
    check("rst_pvalid", bus.pix_valid, 0);
    check("rst_pcolor", bus.pix_color, 0);
    check("rst_plast", bus.pix_last, 0);
    check("rst_drop", bus.drop_count, 0);
    bus.hit_valid = '0;
    rst = 1'b0;
    n = 0;
    while (bus.busy && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("rst_to_idle", n, DEPTH);
    model_clear();

    // cleared store readout
    do_dump(1'b0, beats, lasts, last_idx, unst, lat);
    check("d0_beats", beats, DEPTH);
    check("d0_latency", lat, 4);
    check("d0_lasts", lasts, 1);
    check("d0_last_idx", last_idx, DEPTH - 1);
    check("d0_image", img_diff(), 0);
    check("d0_busy_after", bus.busy, 0);

    // two lanes competing, distinct addresses
    i0 = 0; i1 = 0; cyc = 0; seq = '0;
    while ((i0 < 4 || i1 < 4) && cyc < 20) begin
      @(negedge clk);
      bus.hit_valid[0]    = (i0 < 4);
      bus.hit_valid[1]    = (i1 < 4);
      bus.hit_xyz[0][0]   = SIGFIG'(i0 * 1024);
      bus.hit_xyz[0][1]   = '0;
      bus.hit_xyz[0][2]   = SIGFIG'(10);
      bus.hit_color[0]    = rgb(16 + i0);
      bus.hit_xyz[1][0]   = SIGFIG'(i1 * 1024);
      bus.hit_xyz[1][1]   = SIGFIG'(1024);
      bus.hit_xyz[1][2]   = SIGFIG'(10);
      bus.hit_color[1]    = rgb(32 + i1);
      #1;
      if (bus.hit_ready[0]) begin
        model_hit(i0 * 8, 10, rgb(16 + i0));
        i0++;
      end else if (bus.hit_ready[1]) begin
        seq[cyc] = 1'b1;
        model_hit(512 + i1 * 8, 10, rgb(32 + i1));
        i1++;
      end
      cyc++;
    end
    idle_hits();
    check("rr_cycles", cyc, 8);
    check("rr_seq", seq, 32'hAA);

    // same-address pairs at 1x: losing then winning second sample
    send(0, 2048, 3072, 100, rgb(7), w); model_hit(1552, 100, rgb(7));
    send(0, 2048, 3072, 200, rgb(9), w); model_hit(1552, 200, rgb(9));
    check("pair_a_gap", w, GAP);
    idle_hits();
    send(0, 4096, 5120, 100, rgb(7), w); model_hit(2592, 100, rgb(7));
    send(0, 4096, 5120, 50, rgb(9), w);  model_hit(2592, 50, rgb(9));
    check("pair_b_gap", w, GAP);
    idle_hits();

    // out-of-tile fragments (x=-1.0 and x=8.0) must not touch the store
    send(0, -1024, 0, 1, rgb(1), w);
    send(0, 8192, 0, 1, rgb(1), w);
    idle_hits();
    @(negedge clk);
    check("drop_count", bus.drop_count, 2);

    // 4x subsampling: x=1.75, y=0.25 -> address 75
    @(negedge clk);
    bus.subSample_RnnnnU = RATE_4X;
    send(0, 1792, 256, 5, rgb3(3, 4, 5), w); model_hit(75, 5, rgb3(3, 4, 5));
    idle_hits();
    @(negedge clk);
    bus.subSample_RnnnnU = RATE_1X;

    do_dump(1'b0, beats, lasts, last_idx, unst, lat);
    check("d1_beats", beats, DEPTH);
    check("d1_image", img_diff(), 0);
    check("d1_pix_2_3", got[1552], rgb(7));
    check("d1_pix_4_5", got[2592], rgb(9));
    check("d1_ss4x", got[75], rgb3(3, 4, 5));
    check("d1_lane0_first", got[0], rgb(16));
    check("d1_lane1_last", got[536], rgb(35));
    check("d1_drop_neg", got[56], 0);
    check("d1_busy_after", bus.busy, 0);

    // readout under alternating backpressure
    do_dump(1'b1, beats, lasts, last_idx, unst, lat);
    check("d2_beats", beats, DEPTH);
    check("d2_image", img_diff(), 0);
    check("d2_stable", unst, 0);
    check("d2_lasts", lasts, 1);
    check("d2_last_idx", last_idx, DEPTH - 1);

    // clear and dump together: clear only
    @(negedge clk);
    bus.clear_req = 1'b1;
    bus.dump_req  = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    bus.dump_req  = 1'b0;
    n = 1;
    pv_seen = 1'b0;
    while (bus.busy && n < 10000) begin
      @(negedge clk);
      n++;
      if (bus.pix_valid) pv_seen = 1'b1;
    end
    check("both_req_len", n, DEPTH + 3);
    check("both_req_nodump", pv_seen, 0);
    repeat (3) @(negedge clk);
    check("both_req_idle", bus.busy, 0);
    model_clear();
    do_dump(1'b0, beats, lasts, last_idx, unst, lat);
    check("d3_beats", beats, DEPTH);
    check("d3_image", img_diff(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
